// File: rtl/digit_serial_adder_if.sv
// rtl/digit_serial_adder_if.sv - start/done handshake and operand/result bundle for digit_serial_adder
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, c_in, sub,
    input  busy, done, s, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in, sub,
    output busy, done, s, c_out, ovf
  );
endinterface

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - WIDTH-bit add/subtract, DIGIT bits per clock, LSB slice first
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  digit_serial_adder_if.slave bus
);
  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("digit_serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last;
  logic [31:0]      base;
  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] merged;
  logic             cin_msb;

  assign accept = (state_q != ST_RUN) && bus.start;
  assign last   = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == ST_RUN);
    bus.done = (state_q == ST_DONE);
  end

  assign bus.s     = s_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;

  // One slice of the ripple: the only adder in the design, DIGIT bits wide.
  always_comb begin
    base      = 32'(cnt_q) * 32'(DIGIT);
    slice_sum = {1'b0, opa_q[base +: DIGIT]} + {1'b0, opb_q[base +: DIGIT]}
              + {{DIGIT{1'b0}}, carry_q};
    merged    = acc_q;
    merged[base +: DIGIT] = slice_sum[DIGIT-1:0];
    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    cin_msb   = slice_sum[DIGIT-1] ^ opa_q[WIDTH-1] ^ opb_q[WIDTH-1];
  end

  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    if (accept) begin
      opa_d   = bus.a;
      opb_d   = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.c_in ^ bus.sub;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      acc_d   = merged;
      carry_d = slice_sum[DIGIT];
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        s_d     = merged;
        c_out_d = slice_sum[DIGIT];
        ovf_d   = cin_msb ^ slice_sum[DIGIT];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - self-checking bench for digit_serial_adder at DIGIT=4, 1 and 16
module tb_digit_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_r [3];
  logic [15:0] a_r, b_r;
  logic        cin_r, sub_r;

  logic        busy_w [3];
  logic        done_w [3];
  logic [15:0] s_w    [3];
  logic        cout_w [3];
  logic        ovf_w  [3];

  int lat_exp [3] = '{4, 16, 1};
  int n_vec = 0;
  int n_bad = 0;

  digit_serial_adder_if #(.WIDTH(16)) if4  ();
  digit_serial_adder_if #(.WIDTH(16)) if1  ();
  digit_serial_adder_if #(.WIDTH(16)) if16 ();

  digit_serial_adder #(.WIDTH(16), .DIGIT(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  digit_serial_adder #(.WIDTH(16), .DIGIT(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  assign if4.start  = start_r[0];
  assign if1.start  = start_r[1];
  assign if16.start = start_r[2];
  assign if4.a = a_r;   assign if1.a = a_r;   assign if16.a = a_r;
  assign if4.b = b_r;   assign if1.b = b_r;   assign if16.b = b_r;
  assign if4.c_in = cin_r; assign if1.c_in = cin_r; assign if16.c_in = cin_r;
  assign if4.sub = sub_r;  assign if1.sub = sub_r;  assign if16.sub = sub_r;

  assign busy_w[0] = if4.busy;  assign busy_w[1] = if1.busy;  assign busy_w[2] = if16.busy;
  assign done_w[0] = if4.done;  assign done_w[1] = if1.done;  assign done_w[2] = if16.done;
  assign s_w[0]    = if4.s;     assign s_w[1]    = if1.s;     assign s_w[2]    = if16.s;
  assign cout_w[0] = if4.c_out; assign cout_w[1] = if1.c_out; assign cout_w[2] = if16.c_out;
  assign ovf_w[0]  = if4.ovf;   assign ovf_w[1]  = if1.ovf;   assign ovf_w[2]  = if16.ovf;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c_out;
    logic        ovf;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bb;
    logic [31:0] sum;
    logic        ov;
    bb  = sub ? ~b : b;
    sum = 32'(a) + 32'(bb) + 32'(cin ^ sub);
    ov  = (a[15] == bb[15]) && (sum[15] != a[15]);
    return {ov, sum[16], sum[15:0]};
  endfunction

  task automatic wait_done(input int w, inout int n);
    while (!done_w[w] && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input int w, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic ts, input logic [15:0] es,
                        input logic ec, input logic eo, input string tag);
    int          n;
    int          nbusy;
    int          held_bad;
    logic [15:0] prev_s;
    prev_s   = s_w[w];
    a_r = ta; b_r = tb_v; cin_r = tc; sub_r = ts;
    start_r[w] = 1'b1;
    tick();
    start_r[w] = 1'b0;
    a_r = 16'($urandom); b_r = 16'($urandom); cin_r = 1'($urandom); sub_r = 1'($urandom);
    n = 0; nbusy = 0; held_bad = 0;
    while (!done_w[w] && n < 64) begin
      if (busy_w[w]) nbusy++;
      if (s_w[w] !== prev_s) held_bad++;
      tick();
      n++;
    end
    chk($sformatf("%s latency", tag), n, lat_exp[w]);
    chk($sformatf("%s busy cycles", tag), nbusy, lat_exp[w]);
    chk($sformatf("%s s held in run", tag), held_bad, 0);
    chk($sformatf("%s s", tag), s_w[w], es);
    chk($sformatf("%s c_out", tag), cout_w[w], ec);
    chk($sformatf("%s ovf", tag), ovf_w[w], eo);
    chk($sformatf("%s busy at done", tag), busy_w[w], 0);
    tick();
    chk($sformatf("%s done one cycle", tag), done_w[w], 0);
  endtask

  initial begin
    int          n;
    int          ndone;
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic        rc, rs;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    tbl[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
    a_r = '0; b_r = '0; cin_r = 1'b0; sub_r = 1'b0;
    tick(); tick();
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("reset busy d%0d", w), busy_w[w], 0);
      chk($sformatf("reset done d%0d", w), done_w[w], 0);
      chk($sformatf("reset s d%0d", w), s_w[w], 0);
      chk($sformatf("reset c_out d%0d", w), cout_w[w], 0);
      chk($sformatf("reset ovf d%0d", w), ovf_w[w], 0);
    end
    rst_n = 1'b1;
    tick();

    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 7; i++)
        run_op(w, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
               tbl[i].s, tbl[i].c_out, tbl[i].ovf, $sformatf("tbl%0d d%0d", i, w));

    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 20; i++) begin
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        m  = model(ra, rb, rc, rs);
        run_op(w, ra, rb, rc, rs, m[15:0], m[16], m[17], $sformatf("rnd%0d d%0d", i, w));
      end

    // start during RUN must not disturb the operation in flight
    a_r = 16'h7FFF; b_r = 16'h0001; cin_r = 1'b0; sub_r = 1'b0;
    start_r[0] = 1'b1; tick(); start_r[0] = 1'b0;
    n = 1; tick();
    a_r = 16'h1111; b_r = 16'h2222; sub_r = 1'b1; start_r[0] = 1'b1;
    n = 2; tick(); start_r[0] = 1'b0;
    wait_done(0, n);
    chk("ignore latency", n, 4);
    chk("ignore s", s_w[0], 16'h8000);
    chk("ignore ovf", ovf_w[0], 1);
    tick();
    chk("ignore no restart", busy_w[0], 0);

    // start held through DONE: back-to-back operations
    a_r = 16'h0005; b_r = 16'h0007; cin_r = 1'b0; sub_r = 1'b1;
    start_r[0] = 1'b1; tick();
    a_r = 16'h1234; b_r = 16'h1111; sub_r = 1'b0;
    n = 0; wait_done(0, n);
    chk("b2b first latency", n, 4);
    chk("b2b first s", s_w[0], 16'hFFFE);
    tick();
    start_r[0] = 1'b0;
    chk("b2b accepted busy", busy_w[0], 1);
    chk("b2b accepted done low", done_w[0], 0);
    n = 0; wait_done(0, n);
    chk("b2b second latency", n, 4);
    chk("b2b second s", s_w[0], 16'h2345);
    tick();

    // reset mid-RUN
    a_r = 16'h7FFF; b_r = 16'h0001; cin_r = 1'b0; sub_r = 1'b0;
    start_r[0] = 1'b1; tick(); start_r[0] = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy_w[0], 0);
    chk("midrst done", done_w[0], 0);
    chk("midrst s", s_w[0], 0);
    chk("midrst c_out", cout_w[0], 0);
    chk("midrst ovf", ovf_w[0], 0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_w[0] || busy_w[0]) ndone++;
    end
    chk("midrst no done after release", ndone, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
